// File: rtl/pixel_ctrl_pkg.sv
// Shared types and elaboration helpers for the pixel readout sequencer.
package pixel_ctrl_pkg;

  // Frame sequencer states, in the order a frame walks through them.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ERASE   = 3'd1,
    ST_EXPOSE  = 3'd2,
    ST_CONVERT = 3'd3,
    ST_READ    = 3'd4,
    ST_STREAM  = 3'd5
  } state_t;

  // Channels captured together by one read group.
  function automatic int ch_per_grp(input int num_ch, input int num_grp);
    return num_ch / num_grp;
  endfunction

  // Width of the channel index carried alongside each streamed word.
  function automatic int ch_idx_w(input int num_ch);
    return $clog2(num_ch);
  endfunction

  // Parameter legality: groups must tile the channels evenly, and at least two
  // channels are needed so the channel index has a non-zero width.
  function automatic bit params_ok(input int data_w, input int num_ch,
                                   input int num_grp, input int erase_cyc,
                                   input int read_cyc, input int exp_w);
    return (data_w >= 1) && (num_ch >= 2) && (num_grp >= 1) &&
           ((num_ch % num_grp) == 0) && (erase_cyc >= 1) &&
           (read_cyc >= 1) && (exp_w >= 1);
  endfunction

endpackage

// File: rtl/pixel_ramp_gen.sv
// Free-running ADC ramp counter with synchronous clear; flags the top code.
module pixel_ramp_gen
  import pixel_ctrl_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  output logic [DATA_W-1:0] ramp_code,
  output logic              last
);

  logic [DATA_W-1:0] ramp_reg;

  // Clear has priority so the ramp always restarts from 0 on a fresh phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ramp_reg <= '0;
    end else if (clr) begin
      ramp_reg <= '0;
    end else if (en) begin
      ramp_reg <= ramp_reg + DATA_W'(1);
    end
  end

  assign ramp_code = ramp_reg;
  assign last      = (ramp_reg == {DATA_W{1'b1}});

endmodule

// File: rtl/pixel_readout_ctrl.sv
// Pixel array sequencer: erase, expose, ramp convert, grouped read, stream out.
module pixel_readout_ctrl
  import pixel_ctrl_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NUM_CH    = 4,
  parameter int NUM_GRP   = 2,
  parameter int ERASE_CYC = 5,
  parameter int READ_CYC  = 3,
  parameter int EXP_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     cont_mode,
  input  logic                     abort,
  input  logic [EXP_W-1:0]         exp_len,
  output logic                     erase,
  output logic                     expose,
  output logic                     convert,
  output logic [NUM_GRP-1:0]       read,
  output logic                     bus_oe,
  output logic [DATA_W-1:0]        ramp_code,
  input  logic [NUM_CH*DATA_W-1:0] pix_bus,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(NUM_CH)-1:0] out_ch,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int CH_PER_GRP = ch_per_grp(NUM_CH, NUM_GRP);
  localparam int CH_IDX_W   = ch_idx_w(NUM_CH);
  localparam int GRP_IDX_W  = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
  localparam int ER_W       = $clog2(ERASE_CYC + 1);
  localparam int RD_W       = $clog2(READ_CYC + 1);
  localparam int CW0        = (EXP_W > ER_W) ? EXP_W : ER_W;
  localparam int CNT_W      = (CW0 > RD_W) ? CW0 : RD_W;

  if (!params_ok(DATA_W, NUM_CH, NUM_GRP, ERASE_CYC, READ_CYC, EXP_W)) begin : g_param_check
    $error("pixel_readout_ctrl: illegal parameter combination");
  end

  state_t               state_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [EXP_W-1:0]     exp_len_reg;
  logic                 cont_reg;
  logic [GRP_IDX_W-1:0] grp_reg;
  logic                 gap_reg;
  logic                 erase_reg;
  logic                 expose_reg;
  logic                 convert_reg;
  logic                 bus_oe_reg;
  logic [NUM_GRP-1:0]   read_reg;
  logic                 out_valid_reg;
  logic [DATA_W-1:0]    out_data_reg;
  logic [CH_IDX_W-1:0]  out_ch_reg;
  logic                 busy_reg;
  logic                 frame_done_reg;

  logic [DATA_W-1:0]    buf_reg  [NUM_CH];
  logic [DATA_W-1:0]    buf_next [NUM_CH];
  logic [DATA_W-1:0]    pix_ch   [NUM_CH];
  logic [CH_IDX_W-1:0]  ch_inc;
  logic                 capture;
  logic                 ramp_last;
  logic                 ramp_clr;
  logic                 ramp_en;

  // Split the flat pixel bus into per-channel codes.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign pix_ch[gi] = pix_bus[gi*DATA_W +: DATA_W];
  end

  // Ramp runs only while in CONVERT; it is held at 0 everywhere else and
  // snaps back to 0 on the same edge that leaves CONVERT or aborts.
  assign ramp_en  = (state_reg == ST_CONVERT);
  assign ramp_clr = abort || (state_reg != ST_CONVERT) || ramp_last;

  pixel_ramp_gen #(
    .DATA_W (DATA_W)
  ) u_ramp (
    .clk       (clk),
    .reset     (reset),
    .clr       (ramp_clr),
    .en        (ramp_en),
    .ramp_code (ramp_code),
    .last      (ramp_last)
  );

  // Capture happens on the edge that ends the final read cycle of a group.
  assign capture = (state_reg == ST_READ) && !gap_reg && (cnt_reg == '0);
  assign ch_inc  = out_ch_reg + CH_IDX_W'(1);

  // Buffer contents after this edge, so the first streamed word can come
  // straight from a group captured on the same edge.
  always_comb begin
    buf_next = buf_reg;
    if (capture) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ((c / CH_PER_GRP) == int'(grp_reg)) begin
          buf_next[c] = pix_ch[c];
        end
      end
    end
  end

  // Frame sequencer with all control outputs registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      exp_len_reg    <= '0;
      cont_reg       <= 1'b0;
      grp_reg        <= '0;
      gap_reg        <= 1'b0;
      erase_reg      <= 1'b0;
      expose_reg     <= 1'b0;
      convert_reg    <= 1'b0;
      bus_oe_reg     <= 1'b0;
      read_reg       <= '0;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_ch_reg     <= '0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      buf_reg        <= '{default: '0};
    end else if (abort) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      grp_reg        <= '0;
      gap_reg        <= 1'b0;
      erase_reg      <= 1'b0;
      expose_reg     <= 1'b0;
      convert_reg    <= 1'b0;
      bus_oe_reg     <= 1'b0;
      read_reg       <= '0;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_ch_reg     <= '0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      buf_reg        <= '{default: '0};
    end else begin
      frame_done_reg <= 1'b0;
      buf_reg        <= buf_next;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            exp_len_reg <= exp_len;
            cont_reg    <= cont_mode;
            state_reg   <= ST_ERASE;
            erase_reg   <= 1'b1;
            busy_reg    <= 1'b1;
            cnt_reg     <= CNT_W'(ERASE_CYC - 1);
          end
        end
        ST_ERASE: begin
          if (cnt_reg == '0) begin
            erase_reg  <= 1'b0;
            expose_reg <= 1'b1;
            state_reg  <= ST_EXPOSE;
            // A zero exposure still exposes for one cycle.
            cnt_reg    <= (exp_len_reg == '0) ? '0 : CNT_W'(exp_len_reg - EXP_W'(1));
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        ST_EXPOSE: begin
          if (cnt_reg == '0) begin
            expose_reg  <= 1'b0;
            convert_reg <= 1'b1;
            bus_oe_reg  <= 1'b1;
            state_reg   <= ST_CONVERT;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        ST_CONVERT: begin
          if (ramp_last) begin
            convert_reg <= 1'b0;
            bus_oe_reg  <= 1'b0;
            state_reg   <= ST_READ;
            read_reg    <= NUM_GRP'(1);
            grp_reg     <= '0;
            gap_reg     <= 1'b0;
            cnt_reg     <= CNT_W'(READ_CYC - 1);
          end
        end
        ST_READ: begin
          if (gap_reg) begin
            gap_reg  <= 1'b0;
            grp_reg  <= grp_reg + GRP_IDX_W'(1);
            read_reg <= NUM_GRP'(1) << (grp_reg + GRP_IDX_W'(1));
            cnt_reg  <= CNT_W'(READ_CYC - 1);
          end else if (cnt_reg == '0) begin
            read_reg <= '0;
            if (grp_reg == GRP_IDX_W'(NUM_GRP - 1)) begin
              state_reg     <= ST_STREAM;
              out_valid_reg <= 1'b1;
              out_data_reg  <= buf_next[0];
              out_ch_reg    <= '0;
            end else begin
              gap_reg <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        ST_STREAM: begin
          if (out_ready) begin
            if (out_ch_reg == CH_IDX_W'(NUM_CH - 1)) begin
              out_valid_reg  <= 1'b0;
              out_data_reg   <= '0;
              out_ch_reg     <= '0;
              frame_done_reg <= 1'b1;
              if (cont_reg) begin
                state_reg <= ST_ERASE;
                erase_reg <= 1'b1;
                cnt_reg   <= CNT_W'(ERASE_CYC - 1);
              end else begin
                state_reg <= ST_IDLE;
                busy_reg  <= 1'b0;
              end
            end else begin
              out_data_reg <= buf_reg[ch_inc];
              out_ch_reg   <= ch_inc;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign erase      = erase_reg;
  assign expose     = expose_reg;
  assign convert    = convert_reg;
  assign bus_oe     = bus_oe_reg;
  assign read       = read_reg;
  assign out_valid  = out_valid_reg;
  assign out_data   = out_data_reg;
  assign out_ch     = out_ch_reg;
  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// Scoreboard bench for pixel_readout_ctrl at default parameters.
module tb_pixel_readout_ctrl;

  localparam int DATA_W    = 8;
  localparam int NUM_CH    = 4;
  localparam int NUM_GRP   = 2;
  localparam int ERASE_CYC = 5;
  localparam int READ_CYC  = 3;
  localparam int EXP_W     = 16;
  localparam int CPG       = NUM_CH / NUM_GRP;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     start;
  logic                     cont_mode;
  logic                     abort;
  logic [EXP_W-1:0]         exp_len;
  logic                     erase;
  logic                     expose;
  logic                     convert;
  logic [NUM_GRP-1:0]       read;
  logic                     bus_oe;
  logic [DATA_W-1:0]        ramp_code;
  logic [NUM_CH*DATA_W-1:0] pix_bus = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic [DATA_W-1:0]        out_data;
  logic [1:0]               out_ch;
  logic                     busy;
  logic                     frame_done;

  pixel_readout_ctrl #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .NUM_GRP(NUM_GRP),
    .ERASE_CYC(ERASE_CYC), .READ_CYC(READ_CYC), .EXP_W(EXP_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .cont_mode(cont_mode),
    .abort(abort), .exp_len(exp_len), .erase(erase), .expose(expose),
    .convert(convert), .read(read), .bus_oe(bus_oe), .ramp_code(ramp_code),
    .pix_bus(pix_bus), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [1:0] ch;
    bit         last;
  } word_t;

  // kind 0: compare val; kind 1: compare all outputs; kind 2: compare busy
  typedef struct {
    string       name;
    int          kind;
    logic [63:0] val;
    logic [63:0] exp;
  } spot_t;

  word_t sb_q[$];
  int    exp_q[$];
  spot_t spot_q[$];

  int  checks = 0;
  int  errors = 0;
  bit  skip = 1'b0;
  bit  cont_exp = 1'b0;
  logic [7:0] vals [NUM_CH];
  int  stall_left = 0;
  int  stall_ch = 2;

  logic [1:0] rd_exp [7] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic spot(input string name, input int kind, input logic [63:0] val, input logic [63:0] exp);
    spot_q.push_back('{name, kind, val, exp});
  endtask

  task automatic push_words(input logic [7:0] v0, input logic [7:0] v1,
                            input logic [7:0] v2, input logic [7:0] v3);
    vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
    for (int c = 0; c < NUM_CH; c++)
      sb_q.push_back('{vals[c], 2'(c), (c == NUM_CH - 1)});
  endtask

  // Pixel array model plus sink: pixel codes are valid only in the final cycle
  // of each group's read window; elsewhere the bus carries differing junk.
  logic [NUM_GRP-1:0] drv_prev_read = '0;
  int                 rd_run = 0;
  always @(posedge clk) begin
    #1;
    if (read != drv_prev_read) rd_run = 1;
    else if (read != '0) rd_run++;
    drv_prev_read = read;
    for (int c = 0; c < NUM_CH; c++) begin
      if (read[c / CPG] && rd_run == READ_CYC)
        pix_bus[c*DATA_W +: DATA_W] = vals[c];
      else
        pix_bus[c*DATA_W +: DATA_W] = vals[c] ^ 8'(1 + $urandom_range(0, 254));
    end
    if (out_valid && int'(out_ch) == stall_ch && stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else begin
      out_ready = 1'b1;
    end
  end

  // Monitor: spot checks, stream scoreboard, frame_done and phase timing.
  bit         hold_active = 0;
  logic [7:0] hold_data;
  logic [1:0] hold_ch;
  bit         done_pending = 0;
  bit         nb_chk = 0;
  int         er_run = 0, ex_run = 0, cv_run = 0, ramp_bad = 0, rd_pos = -1;
  always @(negedge clk) begin
    spot_t sp;
    word_t w;
    bit    done_next;
    int    e;
    while (spot_q.size() > 0) begin
      sp = spot_q.pop_front();
      case (sp.kind)
        1: check(sp.name, 64'({erase, expose, convert, read, bus_oe, ramp_code,
                               out_valid, out_data, out_ch, busy, frame_done}), sp.exp);
        2: check(sp.name, 64'(busy), sp.exp);
        default: check(sp.name, sp.val, sp.exp);
      endcase
    end

    if (hold_active) check("stream_hold", {out_valid, out_ch, out_data}, {1'b1, hold_ch, hold_data});
    if (nb_chk) check("no_bubble", 64'(out_valid), 64'd1);
    nb_chk = 0;
    if (frame_done || done_pending)
      check("frame_done", {frame_done, erase, busy},
            {done_pending, cont_exp & done_pending, cont_exp & done_pending});
    done_next = 0;
    if (out_valid && out_ready) begin
      $display("[%0t] word ch=%0d data=%02h", $time, out_ch, out_data);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got ch=%0d data=%02h, expected none", out_ch, out_data);
      end else begin
        w = sb_q.pop_front();
        check("stream_word", {out_ch, out_data}, {w.ch, w.data});
        done_next = w.last;
        nb_chk = !w.last;
      end
      hold_active = 0;
    end else if (out_valid) begin
      hold_active = 1;
      hold_data = out_data;
      hold_ch = out_ch;
    end else begin
      hold_active = 0;
    end
    done_pending = done_next;

    if (erase) er_run++;
    else begin
      if (er_run > 0 && !skip) check("erase_len", er_run, ERASE_CYC);
      er_run = 0;
    end
    if (expose) ex_run++;
    else begin
      if (ex_run > 0 && !skip) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        check("expose_len", ex_run, e);
      end
      ex_run = 0;
    end
    if (convert) begin
      if (ramp_code !== 8'(cv_run) || bus_oe !== 1'b1) ramp_bad++;
      cv_run++;
    end else begin
      if (cv_run > 0 && !skip) begin
        check("convert_len", cv_run, 256);
        check("ramp_trace_errs", ramp_bad, 0);
        check("convert_exit", {bus_oe, ramp_code}, 0);
        rd_pos = 0;
      end
      cv_run = 0;
      ramp_bad = 0;
    end
    if (rd_pos >= 0) begin
      if (rd_pos < 7) check("read_seq", {bus_oe, read}, {1'b0, rd_exp[rd_pos]});
      else check("stream_start", 64'(out_valid), 64'd1);
      rd_pos++;
      if (rd_pos > 7) rd_pos = -1;
    end
  end

  // Single-shot frame; latency counts negedges from start to frame_done.
  task automatic run_frame(input int e, input int stall, input int lat, input bit poke,
                           input logic [7:0] v0, input logic [7:0] v1,
                           input logic [7:0] v2, input logic [7:0] v3);
    int n;
    push_words(v0, v1, v2, v3);
    exp_q.push_back((e < 1) ? 1 : e);
    cont_exp = 0;
    stall_left = stall;
    exp_len = 16'(e);
    cont_mode = 0;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (poke && n == 100) start = 1;
      if (poke && n == 101) start = 0;
      if (frame_done || n >= 3000) break;
    end
    @(posedge clk); #1;
    spot("frame_latency", 0, 64'(n), 64'(lat));
  endtask

  initial begin
    int n;
    reset = 0; start = 0; cont_mode = 0; abort = 0; exp_len = '0;
    for (int c = 0; c < NUM_CH; c++) vals[c] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    spot("reset_outputs", 1, 0, 0);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;

    // Basic frame, then same data with backpressure on word 2 and a stray start.
    run_frame(10, 0, 283, 0, 8'h11, 8'h22, 8'h33, 8'h44);
    run_frame(10, 7, 290, 1, 8'h11, 8'h22, 8'h33, 8'h44);

    // Continuous mode with zero exposure: three back-to-back frames.
    push_words(8'h5A, 8'h6B, 8'h7C, 8'h8D);
    for (int f = 0; f < 3; f++) exp_q.push_back(1);
    cont_exp = 1;
    exp_len = '0;
    cont_mode = 1;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    cont_mode = 0;
    for (int f = 0; f < 3; f++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!frame_done && n < 3000);
      @(posedge clk); #1;
      spot("cont_latency", 0, 64'(n), (f == 0) ? 64'd274 : 64'd273);
      if (f == 0) push_words(8'hA5, 8'hB6, 8'hC7, 8'hD8);
      if (f == 1) push_words(8'h01, 8'hF0, 8'h0F, 8'hFF);
    end
    skip = 1;
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    spot("abort_in_erase", 1, 0, 0);
    cont_exp = 0;
    @(posedge clk); #1;
    skip = 0;

    // Abort while the ramp sits at 100.
    skip = 1;
    exp_len = 16'd3;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!(convert && ramp_code == 8'd99) && n < 2000);
    spot("abort_reach_99", 0, 64'(ramp_code), 64'd99);
    @(posedge clk); #1;
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    spot("abort_outputs", 1, 0, 0);
    repeat (4) begin @(posedge clk); #1; end
    spot("abort_idle", 1, 0, 0);
    skip = 0;
    run_frame(2, 0, 275, 0, 8'h9A, 8'hBC, 8'hDE, 8'hF0);

    // Asynchronous reset in the middle of EXPOSE, start held during reset.
    skip = 1;
    exp_len = 16'd20;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!expose && n < 2000);
    spot("reach_expose", 0, 64'(expose), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    start = 1;
    spot("reset_async", 1, 0, 0);
    @(posedge clk); #1;
    spot("reset_hold", 1, 0, 0);
    @(posedge clk); #3;
    start = 0;
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    spot("idle_after_reset", 2, 0, 0);
    skip = 0;
    run_frame(10, 0, 283, 0, 8'h01, 8'h02, 8'h03, 8'h04);

    repeat (5) @(posedge clk);
    #1;
    spot("scoreboard_drained", 0, 64'(sb_q.size()), 0);
    spot("expose_q_drained", 0, 64'(exp_q.size()), 0);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
